demux16_4_buffered: RTL

Registered 1-to-4 demultiplexer for 16-bit datapath words: it routes each accepted input word to one of four output channels. Each channel holds a one-entry buffer with its own valid/ready handshake. It sits on the write-back side of the PANZER16 datapath, opposite the 4-to-1 operand mux, distributing a result word to one of four destination units.

---
 rtl/demux16_4_buffered.sv | 87 ++++++++
 1 files changed

// File: rtl/demux16_4_buffered.sv
// ============================================================================
// Module   : demux16_4_buffered
// Purpose  : Registered 1-to-4 demultiplexer for 16-bit words, one-entry
//            valid/ready buffer per channel plus a delivered-word counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux16_4_buffered (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] InData,
    input  logic [1:0]  Sel,
    input  logic        InValid,
    output logic        InReady,
    output logic [15:0] Output1,
    output logic [15:0] Output2,
    output logic [15:0] Output3,
    output logic [15:0] Output4,
    output logic [3:0]  OutValid,
    input  logic [3:0]  OutReady,
    output logic [7:0]  DeliveredCount
);

    logic [15:0] data_q [4];
    logic [15:0] data_d [4];
    logic [3:0]  valid_q;
    logic [3:0]  valid_d;
    logic [7:0]  count_q;
    logic [7:0]  count_d;

    logic        w_in_xfer;
    logic [3:0]  w_sel_onehot;
    logic [3:0]  w_drain;
    logic [2:0]  w_drain_num;

    // Readiness looks only at the addressed channel, so a stalled channel
    // never holds up words destined elsewhere.
    assign InReady      = !valid_q[Sel] || OutReady[Sel];
    assign w_in_xfer    = InValid && InReady;
    assign w_sel_onehot = 4'b0001 << Sel;
    assign w_drain      = valid_q & OutReady;
    assign w_drain_num  = {2'b00, w_drain[0]} + {2'b00, w_drain[1]}
                        + {2'b00, w_drain[2]} + {2'b00, w_drain[3]};

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q + {5'b00000, w_drain_num};
        for (int k = 0; k < 4; k++) begin
            // A load wins over a simultaneous drain; a drain alone leaves
            // the data register untouched so the output stays stable.
            if (w_in_xfer && w_sel_onehot[k]) begin
                data_d[k]  = InData;
                valid_d[k] = 1'b1;
            end else if (w_drain[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= 16'h0000;
            end
            valid_q <= 4'b0000;
            count_q <= 8'h00;
        end else begin
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign Output1        = data_q[0];
    assign Output2        = data_q[1];
    assign Output3        = data_q[2];
    assign Output4        = data_q[3];
    assign OutValid       = valid_q;
    assign DeliveredCount = count_q;

endmodule

`default_nettype wire
